// File: rtl/mips_multicycle_datapath_if.sv
// Instruction handshake and retirement status bus of the multi-cycle MIPS core.
interface mips_multicycle_datapath_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  logic            done;
  logic            illegal;
  logic [31:0]     pc;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic [31:0]     retired;

  modport master (
    output instr_valid, instr,
    input  instr_ready, done, illegal, pc, alu_result, zero, retired
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, done, illegal, pc, alu_result, zero, retired
  );
endinterface

// File: rtl/mips_multicycle_datapath.sv
// Multi-cycle MIPS-I subset core: IDLE/DECODE/EXEC/MEM/WB sequencing one
// instruction at a time, with on-chip register file and data memory.
module mips_multicycle_datapath #(
  parameter int          XLEN       = 32,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] PC_RESET   = 32'h0
) (
  input  logic clk,
  input  logic rst,
  mips_multicycle_datapath_if.slave bus
);
  localparam int AW = $clog2(DMEM_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  state_t state, state_nxt;

  logic [31:0]     ir, pc, retired, pc4, pc_nxt;
  logic [XLEN-1:0] rf   [32];
  logic [XLEN-1:0] dmem [DMEM_WORDS];
  logic [XLEN-1:0] a, b, imm, mdr, alu_q, alu_y;
  logic            zero_q, done, illegal, legal;
  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd, dst;
  logic [AW-1:0]   idx;
  logic            is_r, is_lw, is_sw, is_beq, is_j;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign is_r   = (op == 6'h00);
  assign is_lw  = (op == 6'h23);
  assign is_sw  = (op == 6'h2B);
  assign is_beq = (op == 6'h04);
  assign is_j   = (op == 6'h02);
  assign legal  = is_r ? (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})
                       : (op inside {6'h08, 6'h23, 6'h2B, 6'h04, 6'h02});
  assign dst    = is_r ? rd : rt;
  // Byte address -> word index; low two bits and bits above the depth drop out.
  assign idx    = alu_q[AW+1:2];
  assign pc4    = pc + 32'd4;

  // ALU: memory ops and ADDI add the immediate, BEQ compares via subtraction.
  always_comb begin
    alu_y = a + imm;
    if (is_r) begin
      case (funct)
        6'h20:   alu_y = a + b;
        6'h22:   alu_y = a - b;
        6'h24:   alu_y = a & b;
        6'h25:   alu_y = a | b;
        6'h2A:   alu_y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        default: alu_y = a + b;
      endcase
    end else if (is_beq) begin
      alu_y = a - b;
    end
  end

  // Next PC at retirement/drop; branch and jump only resolve in EXEC.
  always_comb begin
    pc_nxt = pc4;
    if (is_j)
      pc_nxt = {pc4[31:28], ir[25:0], 2'b00};
    else if (is_beq && alu_y == '0)
      pc_nxt = pc4 + {{14{ir[15]}}, ir[15:0], 2'b00};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and the done/illegal pulses.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_IDLE:   if (bus.instr_valid) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!legal) begin
          illegal   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq || is_j) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // IR capture, operand fetch, ALU latch and load data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      imm    <= '0;
      mdr    <= '0;
      alu_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      if (state == S_IDLE && bus.instr_valid) ir <= bus.instr;
      if (state == S_DECODE) begin
        a   <= rf[rs];
        b   <= rf[rt];
        imm <= {{(XLEN-16){ir[15]}}, ir[15:0]};
      end
      if (state == S_EXEC) begin
        alu_q  <= alu_y;
        zero_q <= (alu_y == '0);
      end
      if (state == S_MEM && is_lw) mdr <= dmem[idx];
    end
  end

  // PC and retirement counter; dropped illegal instructions advance pc only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= PC_RESET;
      retired <= '0;
    end else begin
      if (done || illegal) pc <= pc_nxt;
      if (done)            retired <= retired + 32'd1;
    end
  end

  // Register file write-back; $0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == S_WB && dst != 5'd0) begin
      rf[dst] <= is_lw ? mdr : alu_q;
    end
  end

  // Data memory store; not reset, and a reset during MEM leaves state IDLE so nothing is written.
  always_ff @(posedge clk) begin
    if (state == S_MEM && is_sw) dmem[idx] <= b;
  end

  assign bus.instr_ready = (state == S_IDLE);
  assign bus.done        = done;
  assign bus.illegal     = illegal;
  assign bus.pc          = pc;
  assign bus.alu_result  = alu_q;
  assign bus.zero        = zero_q;
  assign bus.retired     = retired;
endmodule
